// File: rtl/srf_ctrl.sv
// Initiator-side controller for the single-bit storage register file: power-on
// zero sweep, then one host command at a time with done/timeout completion.
module srf_ctrl #(
  parameter int AW  = 2,
  parameter int DW  = 1,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rd,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          init_busy,
  output logic          init_err,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout,
  input  logic          mem_done
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  state_t        state_q, state_d;
  logic          sweep_q, sweep_d;
  logic [AW-1:0] swp_cnt_q, swp_cnt_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          init_busy_q, init_busy_d;
  logic          init_err_q, init_err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_add_q, mem_add_d;
  logic [DW-1:0] mem_datain_q, mem_datain_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // State and registered-output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      sweep_q      <= 1'b0;
      swp_cnt_q    <= '0;
      tmo_cnt_q    <= 8'd0;
      init_busy_q  <= 1'b1;
      init_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b1;
      mem_add_q    <= '0;
      mem_datain_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      swp_cnt_q    <= swp_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      init_busy_q  <= init_busy_d;
      init_err_q   <= init_err_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_add_q    <= mem_add_d;
      mem_datain_q <= mem_datain_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    swp_cnt_d    = swp_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    init_busy_d  = init_busy_q;
    init_err_d   = init_err_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_add_d    = mem_add_q;
    mem_datain_d = mem_datain_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_INIT: begin
        mem_req_d    = 1'b1;
        mem_wr_d     = 1'b0;
        mem_add_d    = swp_cnt_q;
        mem_datain_d = '0;
        sweep_d      = 1'b1;
        state_d      = S_WAIT;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          mem_req_d    = 1'b1;
          mem_wr_d     = cmd_rd;
          mem_add_d    = cmd_addr;
          mem_datain_d = cmd_wdata;
          sweep_d      = 1'b0;
          state_d      = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (mem_done) begin
          mem_req_d = 1'b0;
          tmo_cnt_d = 8'd0;
          if (sweep_q) begin
            if (swp_cnt_q == ADDR_MAX) begin
              init_busy_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              swp_cnt_d = swp_cnt_q + AW'(1);
              state_d   = S_INIT;
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = mem_wr_q ? mem_dataout : '0;
            state_d     = S_RESP;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          tmo_cnt_d = 8'd0;
          if (sweep_q) begin
            init_err_d  = 1'b1;
            init_busy_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        tmo_cnt_d   = 8'd0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign init_busy  = init_busy_q;
  assign init_err   = init_err_q;
  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_add    = mem_add_q;
  assign mem_datain = mem_datain_q;

endmodule
